// File: rtl/sd_decimator_pkg.sv
// Shared CIC constants and width helpers for the sigma-delta decimator and its DAC-side models.
package sd_decimator_pkg;

  localparam int CIC_ORDER = 3;

  // Integrator/comb width: enough headroom for R^ORDER gain plus one bit.
  function automatic int cic_acc_w(input int decim_log2);
    return CIC_ORDER * decim_log2 + 1;
  endfunction

  function automatic int cic_shift(input int decim_log2, input int out_w);
    return CIC_ORDER * decim_log2 - out_w;
  endfunction

endpackage

// File: rtl/sd_cic_comb.sv
// One registered CIC comb stage: out = in - previous in, updated only on in_vld.
// Latency 1 clk; no backpressure, out_vld is in_vld delayed by one cycle.
module sd_cic_comb
  import sd_decimator_pkg::*;
#(
  parameter int W = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_dat,
  input  logic         in_vld,
  output logic [W-1:0] out_dat,
  output logic         out_vld
);

  logic [W-1:0] z_q, z_d;
  logic [W-1:0] out_q, out_d;
  logic         vld_q, vld_d;

  always_comb begin
    z_d   = z_q;
    out_d = out_q;
    vld_d = in_vld;
    if (in_vld) begin
      out_d = in_dat - z_q;
      z_d   = in_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q   <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      z_q   <= z_d;
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end

  assign out_dat = out_q;
  assign out_vld = vld_q;

endmodule

// File: rtl/sd_decimator.sv
// 1-bit sigma-delta bitstream to unsigned PCM via sinc^3 decimation by 2^DECIM_LOG2.
// Strobe 4 clk after the tick edge; din is only consumed when din_valid=1, no backpressure.
module sd_decimator
  import sd_decimator_pkg::*;
#(
  parameter int DECIM_LOG2 = 10,
  parameter int OUT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid
);

  localparam int ACC_W = cic_acc_w(DECIM_LOG2);
  localparam int SHIFT = cic_shift(DECIM_LOG2, OUT_W);

  logic [ACC_W-1:0]      i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [ACC_W-1:0]      x_q, x_d;
  logic                  x_vld_q, x_vld_d;
  logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
  logic [1:0]            warm_q, warm_d;
  logic                  ok_q, ok_d;
  logic [OUT_W-1:0]      dout_q, dout_d;
  logic                  dout_vld_q, dout_vld_d;
  logic                  tick;
  logic [ACC_W-1:0]      c1, c2, c3, y_full;
  logic                  c1_vld, c2_vld, c3_vld;

  always_comb begin
    i1_d = i1_q;
    i2_d = i2_q;
    i3_d = i3_q;
    cnt_d = cnt_q;
    tick = 1'b0;
    if (din_valid) begin
      i1_d  = i1_q + ACC_W'(din);
      i2_d  = i2_q + i1_q;
      i3_d  = i3_q + i2_q;
      cnt_d = cnt_q + DECIM_LOG2'(1);
      tick  = (cnt_q == '1);
    end

    x_d     = tick ? i3_d : x_q;
    x_vld_d = tick;
    warm_d  = (tick && warm_q != 2'd3) ? warm_q + 2'd1 : warm_q;
    // Ticks are >= 8 clk apart, so this flag stays stable while its sample is in the pipe.
    ok_d    = tick ? (warm_q == 2'd3) : ok_q;

    y_full     = c3 >> SHIFT;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    if (c3_vld && ok_q) begin
      dout_d     = (|y_full[ACC_W-1:OUT_W]) ? '1 : y_full[OUT_W-1:0];
      dout_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i1_q       <= '0;
      i2_q       <= '0;
      i3_q       <= '0;
      x_q        <= '0;
      x_vld_q    <= 1'b0;
      cnt_q      <= '0;
      warm_q     <= '0;
      ok_q       <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      i1_q       <= i1_d;
      i2_q       <= i2_d;
      i3_q       <= i3_d;
      x_q        <= x_d;
      x_vld_q    <= x_vld_d;
      cnt_q      <= cnt_d;
      warm_q     <= warm_d;
      ok_q       <= ok_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  sd_cic_comb #(.W(ACC_W)) u_comb1 (
    .clk(clk), .rst(rst), .in_dat(x_q), .in_vld(x_vld_q), .out_dat(c1), .out_vld(c1_vld)
  );
  sd_cic_comb #(.W(ACC_W)) u_comb2 (
    .clk(clk), .rst(rst), .in_dat(c1), .in_vld(c1_vld), .out_dat(c2), .out_vld(c2_vld)
  );
  sd_cic_comb #(.W(ACC_W)) u_comb3 (
    .clk(clk), .rst(rst), .in_dat(c2), .in_vld(c2_vld), .out_dat(c3), .out_vld(c3_vld)
  );

  assign dout       = dout_q;
  assign dout_valid = dout_vld_q;

endmodule
